// File: rtl/wt_mem_req_arbiter_if.sv
// Request/memory/response bundle between the caches, the arbiter and the memory adapter.
// The master side is the environment (caches plus adapter); the slave side is the arbiter.
interface wt_mem_req_arbiter_if #(
  parameter int unsigned NrReq     = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned TidWidth  = 3
);
  logic [NrReq-1:0]           req_valid_i;
  logic [NrReq-1:0]           req_ready_o;
  logic [NrReq*AddrWidth-1:0] req_addr_i;
  logic [NrReq-1:0]           req_we_i;
  logic [NrReq*DataWidth-1:0] req_wdata_i;

  logic                       mem_valid_o;
  logic                       mem_ready_i;
  logic [AddrWidth-1:0]       mem_addr_o;
  logic                       mem_we_o;
  logic [DataWidth-1:0]       mem_wdata_o;
  logic [TidWidth-1:0]        mem_tid_o;

  logic                       rsp_valid_i;
  logic [TidWidth-1:0]        rsp_tid_i;
  logic [DataWidth-1:0]       rsp_data_i;
  logic [NrReq-1:0]           rsp_valid_o;
  logic [DataWidth-1:0]       rsp_data_o;

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i,
    input  req_ready_o,
    input  mem_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_tid_o,
    output mem_ready_i,
    output rsp_valid_i, rsp_tid_i, rsp_data_i,
    input  rsp_valid_o, rsp_data_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i,
    output req_ready_o,
    output mem_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_tid_o,
    input  mem_ready_i,
    input  rsp_valid_i, rsp_tid_i, rsp_data_i,
    output rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port between NrReq caches, with a registered request
// slot, per-request TID allocation, an outstanding-transaction cap and TID-based response routing.
module wt_mem_req_arbiter #(
  parameter int unsigned NrReq          = 2,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned TidWidth       = 3,
  parameter int unsigned MaxOutstanding = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  wt_mem_req_arbiter_if.slave    bus,
  output logic                   idle_o,
  output logic                   err_o
);
  localparam int unsigned NumTid   = 1 << TidWidth;
  localparam int unsigned IdxWidth = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  logic [0:0]           slot_state;
  logic [AddrWidth-1:0] slot_addr;
  logic                 slot_we;
  logic [DataWidth-1:0] slot_wdata;
  logic [TidWidth-1:0]  slot_tid;
  logic [NumTid-1:0]    busy_q;
  logic [IdxWidth-1:0]  owner_q [NumTid];
  logic [CntWidth-1:0]  count_q;
  logic [IdxWidth-1:0]  rr_q;
  logic                 err_q;

  logic                 gnt_found, alloc_found, can_accept, accept, rsp_hit;
  logic [IdxWidth-1:0]  gnt_idx;
  logic [TidWidth-1:0]  alloc_tid;
  logic [AddrWidth-1:0] gnt_addr;
  logic                 gnt_we;
  logic [DataWidth-1:0] gnt_wdata;
  logic [NumTid-1:0]    busy_next;

  always_comb begin : grant_select
    logic [IdxWidth-1:0] cand;
    // NOTE: every signal gets a default before the loops so no path leaves it unassigned (no latch).
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NrReq; k++) begin
      cand = IdxWidth'((32'(rr_q) + 32'(k)) % NrReq);
      if (!gnt_found && bus.req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_addr  = '0;
    gnt_we    = 1'b0;
    gnt_wdata = '0;
    for (int i = 0; i < NrReq; i++) begin
      if (IdxWidth'(i) == gnt_idx) begin
        gnt_addr  = bus.req_addr_i[i*AddrWidth +: AddrWidth];
        gnt_we    = bus.req_we_i[i];
        gnt_wdata = bus.req_wdata_i[i*DataWidth +: DataWidth];
      end
    end
  end

  // Allocation looks only at the registered table, so a TID freed this cycle is reusable next cycle.
  always_comb begin : tid_alloc
    alloc_found = 1'b0;
    alloc_tid   = '0;
    for (int t = 0; t < NumTid; t++) begin
      if (!alloc_found && !busy_q[t]) begin
        alloc_found = 1'b1;
        alloc_tid   = TidWidth'(t);
      end
    end
  end

  assign can_accept = rst_ni && !flush_i && (slot_state == SLOT_EMPTY || bus.mem_ready_i) &&
                      (count_q < CntWidth'(MaxOutstanding)) && alloc_found;
  assign accept     = can_accept && gnt_found;
  assign rsp_hit    = bus.rsp_valid_i && busy_q[bus.rsp_tid_i];

  always_comb begin : outputs_comb
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    if (accept)  bus.req_ready_o[gnt_idx] = 1'b1;
    if (rsp_hit) bus.rsp_valid_o[owner_q[bus.rsp_tid_i]] = 1'b1;
    busy_next = busy_q;
    if (accept)  busy_next[alloc_tid] = 1'b1;
    if (rsp_hit) busy_next[bus.rsp_tid_i] = 1'b0;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_state <= SLOT_EMPTY;
      slot_addr  <= '0;
      slot_we    <= 1'b0;
      slot_wdata <= '0;
      slot_tid   <= '0;
      busy_q     <= '0;
      count_q    <= '0;
      rr_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        slot_state <= SLOT_FULL;
        slot_addr  <= gnt_addr;
        slot_we    <= gnt_we;
        slot_wdata <= gnt_wdata;
        slot_tid   <= alloc_tid;
        rr_q       <= (gnt_idx == IdxWidth'(NrReq - 1)) ? '0 : gnt_idx + IdxWidth'(1);
      end else if (bus.mem_ready_i) begin
        slot_state <= SLOT_EMPTY;
      end
      busy_q <= busy_next;
      unique case ({accept, rsp_hit})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
      if (bus.rsp_valid_i && !busy_q[bus.rsp_tid_i]) err_q <= 1'b1;
    end
  end

  // NOTE: the owner table has no reset; an entry is only read while its busy bit is set.
  always_ff @(posedge clk_i) begin
    if (accept) owner_q[alloc_tid] <= gnt_idx;
  end

  assign bus.mem_valid_o = (slot_state == SLOT_FULL);
  assign bus.mem_addr_o  = slot_addr;
  assign bus.mem_we_o    = slot_we;
  assign bus.mem_wdata_o = slot_wdata;
  assign bus.mem_tid_o   = slot_tid;
  assign bus.rsp_data_o  = bus.rsp_data_i;
  assign idle_o          = (slot_state == SLOT_EMPTY) && (count_q == '0);
  assign err_o           = err_q;
endmodule
